and_gate_response_checker: RTL
==============================

# and_gate_response_checker

Synthesizable response checker for the N-input AND gate lab. It is the receiving end of the exhaustive stimulus sweep: it samples each applied input vector together with the gate's observed output and compares the output against the expected reduction-AND. It tracks which of the 2^N_IN vectors have been seen and counts mismatches. It reports pass/fail when coverage is complete or a timeout expires. It sits on the FPGA board between the stimulus counter/switches and the LED/7-segment status logic.

## Interface
- N_IN, 4, gate input count; legal range 1..5; the coverage mask is 2^N_IN bits.
- ERR_W, 8, width of the saturating mismatch counter.
- TIMEOUT, 1000, cycles allowed in CHECK after start before forced completion; must be ≥ 2^N_IN.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; arms a new sweep. Honoured only in IDLE or DONE.
- vec_valid  input  1  vec/y_obs are valid this cycle.
- vec  input  N_IN  applied input vector (a is the MSB, the last input is the LSB).
- y_obs  input  1  observed gate output for vec.
- busy  output  1  high in CHECK.
- done  output  1  high in DONE.
- pass  output  1  done && err_count==0 && !timeout.
- timeout  output  1  sweep ended by TIMEOUT rather than full coverage.
- err_count  output  ERR_W  mismatches this sweep; saturates at all-ones.
- cover_mask  output  2^N_IN  bit k set once vector k has been sampled.
- first_fail_vec  output  N_IN  first mismatching vector (feature-gated, see Configuration).
- first_fail_valid  output  1  first_fail_vec holds a capture.

## Operation
- States: IDLE → CHECK on start; CHECK → DONE on full coverage or timeout; DONE → CHECK on start; any state → IDLE on rst.
- On entry to CHECK, clear err_count, cover_mask, timeout, the timeout counter, first_fail_valid, and first_fail_vec.
- In CHECK, with vec_valid high:
  - expected = &vec.
  - mismatch = (y_obs != expected); on mismatch, increment err_count (saturating).
  - Set cover_mask[vec].
- Duplicate vectors are rechecked, and each mismatch is counted again; their coverage bit is already set.
- vec_valid in IDLE or DONE is ignored. start in CHECK is ignored.
- Completion: if the next cover_mask value is all-ones, go to DONE. Otherwise, if the timeout counter reaches TIMEOUT-1, go to DONE with timeout=1.
- If coverage completes and the timeout triggers in the same cycle, coverage wins (timeout=0).
- DONE holds all results stable until start or rst.

## Timing
- Reset values: state IDLE, and every output 0.
- A sample presented in cycle t is reflected in err_count/cover_mask at t+1.
- done rises at t+1 when the final new vector is sampled at t.
- pass/timeout are valid whenever done=1.
- The timeout counter increments every CHECK cycle, regardless of vec_valid.
- rst mid-sweep discards all results; the next start begins a clean sweep.
- Back-to-back vec_valid every cycle is supported; no backpressure exists.

## Configuration
- FIRST_FAIL_CAPTURE_EN defined:
  - first_fail_vec/first_fail_valid capture vec on the first mismatch of a sweep.
  - They hold until the next start or rst; later mismatches do not overwrite them.
- Undefined: both outputs are tied to 0, and no capture register is built.

## Structure
- Shared package and_chk_pkg:
  - state enum (IDLE, CHECK, DONE);
  - a function expected_and(vec);
  - default N_IN/ERR_W/TIMEOUT constants.
- One sub-module, and_chk_timeout_ctr: a loadable down-counter with clear and expire outputs.
- The rest is a single FSM + datapath.

## Test plan
- rst high 2 cycles → all outputs 0, busy=0. start, then vectors 0..15 with y_obs=(vec==15) → done one cycle after vec 15, pass=1, err_count=0, cover_mask=16'hFFFF.
- Same sweep but y_obs=1 at vec=5 and vec=9 → err_count=2, pass=0. With FIRST_FAIL_CAPTURE_EN: first_fail_vec=5, first_fail_valid=1.
- start, apply only vectors 0..14, then idle → done at cycle TIMEOUT after CHECK entry, timeout=1, cover_mask=16'h7FFF, pass=0.
- Vector 3 repeated 4 times with y_obs=1, then full correct sweep → err_count=4, with coverage still completing normally.
- Assert rst at vec 7 mid-sweep → IDLE, outputs 0. The next start plus a full correct sweep gives pass=1.
- ERR_W=2, all 16 vectors with inverted y_obs → err_count saturates at 3, pass=0. start pulsed during CHECK has no effect.

Source files
------------

// File: rtl/and_chk_pkg.sv
// Shared types, defaults and the reference AND reduction for the AND gate response checker.
package and_chk_pkg;

  localparam int unsigned N_IN_DEF    = 4;
  localparam int unsigned ERR_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 1000;
  localparam int unsigned MAX_N       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } chk_state_t;

  // Only the low n bits of v are gate inputs; the rest are padding.
  function automatic logic expected_and(input logic [MAX_N-1:0] v, input int unsigned n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r = r & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/and_chk_timeout_ctr.sv
// Loadable down-counter; expire is high while the count sits at zero.
module and_chk_timeout_ctr #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/and_gate_response_checker.sv
// Response checker for the N-input AND gate sweep: coverage mask, mismatch count, timeout.
// Optional first-mismatch capture is built when FIRST_FAIL_CAPTURE_EN is defined.
module and_gate_response_checker
  import and_chk_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned ERR_W   = ERR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  vec_valid,
  input  logic [N_IN-1:0]       vec,
  input  logic                  y_obs,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_W-1:0]      err_count,
  output logic [(1<<N_IN)-1:0]  cover_mask,
  output logic [N_IN-1:0]       first_fail_vec,
  output logic                  first_fail_valid
);

  localparam int unsigned COV_W = 1 << N_IN;
  localparam int unsigned CTR_W = $clog2(TIMEOUT + 1);

  // Handshake: vec/y_obs are consumed in every CHECK cycle where vec_valid is high;
  // there is no ready, so the source may present a new sample every cycle.

  chk_state_t state, state_nx;
  logic             start_ok;
  logic             sample;
  logic             mismatch;
  logic             all_cov;
  logic             finish_to;
  logic             expire;
  logic [MAX_N-1:0] vec_ext;
  logic [COV_W-1:0] vec_bit;
  logic [COV_W-1:0] mask_nx;

  assign start_ok = start && (state != CHECK);
  assign sample   = (state == CHECK) && vec_valid;

  always_comb begin
    vec_ext = '0;
    vec_ext[N_IN-1:0] = vec;
  end

  assign mismatch = sample && (y_obs != expected_and(vec_ext, N_IN));
  assign vec_bit  = sample ? (COV_W'(1) << vec) : '0;
  assign mask_nx  = cover_mask | vec_bit;
  assign all_cov  = &mask_nx;

  and_chk_timeout_ctr #(.W(CTR_W)) u_timeout_ctr (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE && !start),
    .load       (start_ok),
    .en         (state == CHECK),
    .load_value (CTR_W'(TIMEOUT - 1)),
    .expire     (expire)
  );

  always_comb begin
    state_nx  = state;
    finish_to = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = CHECK;
      CHECK: begin
        // Coverage has priority over a simultaneous timeout.
        if (all_cov) begin
          state_nx = DONE;
        end else if (expire) begin
          state_nx  = DONE;
          finish_to = 1'b1;
        end
      end
      DONE:  if (start) state_nx = CHECK;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      err_count  <= '0;
      cover_mask <= '0;
      timeout    <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        err_count  <= '0;
        cover_mask <= '0;
        timeout    <= 1'b0;
      end else if (state == CHECK) begin
        cover_mask <= mask_nx;
        if (mismatch && (err_count != '1)) err_count <= err_count + ERR_W'(1);
        if (finish_to) timeout <= 1'b1;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [N_IN-1:0] ff_vec;
  logic            ff_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_vec   <= '0;
      ff_valid <= 1'b0;
    end else if (start_ok) begin
      ff_vec   <= '0;
      ff_valid <= 1'b0;
    end else if (mismatch && !ff_valid) begin
      ff_vec   <= vec;
      ff_valid <= 1'b1;
    end
  end

  assign first_fail_vec   = ff_vec;
  assign first_fail_valid = ff_valid;
`else
  assign first_fail_vec   = '0;
  assign first_fail_valid = 1'b0;
`endif

  assign busy = (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0) && !timeout;

endmodule
